serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/rca_slice.sv | 27 ++
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int sliceCount(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-slice operation still needs one counter bit so the port widths stay legal.
    function automatic int cntWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// SLICE-bit ripple-carry chain of full-adder cells; also exposes the carry into its MSB.
module rca_slice
    import serial_adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : gCell
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co       = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor that processes SLICE bits per clock through one rca_slice.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = sliceCount(WIDTH, SLICE);
    localparam int CW = cntWidth(N);

    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : gBadSlice
        $error("serial_adder: WIDTH must be an integer multiple of SLICE");
    end

    state_e           state_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    int               sliceBase;
    logic             isLast;
    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic [SLICE-1:0] sliceS;
    logic             sliceCo;
    logic             sliceMsbCi;

    always_comb begin
        sliceBase = int'(cnt_q) * SLICE;
        sliceA    = opA_q[sliceBase +: SLICE];
        sliceB    = opB_q[sliceBase +: SLICE];
        cnt_d     = cnt_q + 1'b1;
        isLast    = (cnt_q == CW'(N - 1));
    end

    rca_slice #(
        .W(SLICE)
    ) uSlice (
        .a       (sliceA),
        .b       (sliceB),
        .ci      (carry_q),
        .s       (sliceS),
        .co      (sliceCo),
        .c_msb_in(sliceMsbCi)
    );

    // Subtraction is folded into capture: B is stored inverted and the carry seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opA_q   <= a;
                        opB_q   <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[sliceBase +: SLICE] <= sliceS;
                    carry_q                   <= sliceCo;
                    if (isLast) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= sliceCo;
                        ovf_q   <= sliceMsbCi ^ sliceCo;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: four instances (SLICE 4, 1, 8, 16) checked against an arithmetic model.
module tb_serial_adder;

    localparam int W    = 16;
    localparam int NDUT = 4;

    typedef struct {
        int           dut;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cycles;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start [NDUT];
    logic         sub   [NDUT];
    logic         cin   [NDUT];
    logic         busy  [NDUT];
    logic         done  [NDUT];
    logic         cout  [NDUT];
    logic         ovf   [NDUT];
    logic [W-1:0] aIn   [NDUT];
    logic [W-1:0] bIn   [NDUT];
    logic [W-1:0] sum   [NDUT];

    exp_t expQ[$];
    int   testsRun  = 0;
    int   failCount = 0;
    int   busyCnt  [NDUT];
    logic prevDone [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int SL = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
        serial_adder #(
            .WIDTH(W),
            .SLICE(SL)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start[g]),
            .sub  (sub[g]),
            .a    (aIn[g]),
            .b    (bIn[g]),
            .cin  (cin[g]),
            .busy (busy[g]),
            .done (done[g]),
            .sum  (sum[g]),
            .cout (cout[g]),
            .ovf  (ovf[g])
        );
    end

    function automatic int sliceOf(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    // Reference: plain integer arithmetic, signed range test for overflow, a >= b for not-borrow.
    function automatic exp_t model(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
        exp_t        e;
        int unsigned ua, ub, ur;
        int          sa, sb, res;
        ua = av;
        ub = bv;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (sv) begin
            ur     = ua - ub;
            e.cout = (ua >= ub);
            res    = sa - sb;
        end else begin
            ur     = ua + ub + (cv ? 1 : 0);
            e.cout = (ur > 32'd65535);
            res    = sa + sb + (cv ? 1 : 0);
        end
        e.dut    = d;
        e.sum    = ur[W-1:0];
        e.ovf    = (res > 32767) || (res < -32768);
        e.cycles = W / sliceOf(d);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        testsRun++;
        if (act !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv, input bit push);
        aIn[d]   = av;
        bIn[d]   = bv;
        cin[d]   = cv;
        sub[d]   = sv;
        start[d] = 1'b1;
        if (push) expQ.push_back(model(d, av, bv, cv, sv));
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    task automatic drainQueue(input int d, input bit scramble);
        int budget = 0;
        while (expQ.size() != 0 && budget < 100) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                aIn[d] = 16'($urandom);
                bIn[d] = 16'($urandom);
                cin[d] = 1'($urandom);
                sub[d] = 1'($urandom);
            end
            budget++;
        end
        if (expQ.size() != 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL drain timeout dut %0d: %0d results outstanding, expected 0", d, expQ.size());
            expQ.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: counts busy cycles per instance and pops/compares one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (!rst_n) begin
                    busyCnt[d]  = 0;
                    prevDone[d] = 1'b0;
                end else begin
                    if (busy[d]) busyCnt[d]++;
                    if (done[d]) begin
                        checkOutput($sformatf("done width[%0d]", d), 32'(prevDone[d]), 32'd0);
                        if (expQ.size() == 0) begin
                            testsRun++;
                            failCount++;
                            $display("[TB] FAIL unexpected done[%0d]: sum 0x%0h, no result expected", d, sum[d]);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput($sformatf("done source[%0d]", d), 32'(d), 32'(e.dut));
                            checkOutput($sformatf("sum[%0d]", d), 32'(sum[d]), 32'(e.sum));
                            checkOutput($sformatf("cout[%0d]", d), 32'(cout[d]), 32'(e.cout));
                            checkOutput($sformatf("ovf[%0d]", d), 32'(ovf[d]), 32'(e.ovf));
                            checkOutput($sformatf("busy cycles[%0d]", d), 32'(busyCnt[d]), 32'(e.cycles));
                        end
                        busyCnt[d] = 0;
                    end
                    prevDone[d] = done[d];
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        for (int d = 0; d < NDUT; d++) begin
            start[d] = 1'b0;
            sub[d]   = 1'b0;
            cin[d]   = 1'b0;
            aIn[d]   = '0;
            bIn[d]   = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("reset busy[%0d]", d), 32'(busy[d]), 32'd0);
            checkOutput($sformatf("reset done[%0d]", d), 32'(done[d]), 32'd0);
            checkOutput($sformatf("reset sum[%0d]", d), 32'(sum[d]), 32'd0);
            checkOutput($sformatf("reset cout[%0d]", d), 32'(cout[d]), 32'd0);
            checkOutput($sformatf("reset ovf[%0d]", d), 32'(ovf[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner vectors then randomized traffic on every slice width.
        for (int d = 0; d < NDUT; d++) begin
            applyStimulus(d, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1); drainQueue(d, 1'b1);
            applyStimulus(d, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1); drainQueue(d, 1'b1);
            applyStimulus(d, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1); drainQueue(d, 1'b1);
            applyStimulus(d, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1); drainQueue(d, 1'b1);
            for (int i = 0; i < 15; i++) begin
                applyStimulus(d, pickOperand(), pickOperand(), 1'($urandom), 1'($urandom), 1'b1);
                drainQueue(d, 1'b1);
            end
        end

        // start pulsed with new operands mid-run must not disturb the accepted operation
        applyStimulus(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        aIn[0]   = 16'hAAAA;
        bIn[0]   = 16'h5555;
        sub[0]   = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        drainQueue(0, 1'b0);

        // start held through the done cycle launches the next operation with no idle gap
        applyStimulus(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1);
        budget = 0;
        while (!done[0] && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("done seen before back-to-back", 32'(done[0]), 32'd1);
        aIn[0]   = 16'h8000;
        bIn[0]   = 16'h0001;
        cin[0]   = 1'b0;
        sub[0]   = 1'b1;
        start[0] = 1'b1;
        expQ.push_back(model(0, 16'h8000, 16'h0001, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        checkOutput("back-to-back busy", 32'(busy[0]), 32'd1);
        drainQueue(0, 1'b0);

        // Reset in the second RUN cycle aborts with no done and clears the held result
        applyStimulus(0, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy[0]), 32'd0);
        checkOutput("abort done", 32'(done[0]), 32'd0);
        checkOutput("abort sum", 32'(sum[0]), 32'd0);
        checkOutput("abort cout", 32'(cout[0]), 32'd0);
        checkOutput("abort ovf", 32'(ovf[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        drainQueue(0, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
